// File: rtl/bool_q1_pkg.sv
// Shared definitions for bool_q1: the reference truth table of F = A ? B : C,
// the default evaluation-counter width, and a type/helper for the three
// captured forms of F.
package bool_q1_pkg;

  // Bit index {a,b,c} selects F; 8'hCA is A ? B : C.
  localparam logic [7:0]  F_TRUTH_TABLE = 8'hCA;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // One registered result from each implementation of F.
  typedef struct packed {
    logic f_d;  // dataflow
    logic f_b;  // behavioral
    logic f_s;  // structural
  } f_forms_t;

  // True when the three forms do not all agree.
  function automatic logic forms_disagree(input f_forms_t forms);
    return !((forms.f_d == forms.f_b) && (forms.f_b == forms.f_s));
  endfunction

endpackage

// File: rtl/bool_q1_gates.sv
// Structural (gate-level) form of F = A·B + A'·C.
// Ports:
//   a, b, c : operands
//   f       : combinational result
module bool_q1_gates
  import bool_q1_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);

  logic a_n;
  logic ab;
  logic anc;

  not u_not  (a_n, a);
  and u_and0 (ab, a, b);
  and u_and1 (anc, a_n, c);
  or  u_or   (f, ab, anc);

endmodule

// File: rtl/bool_q1.sv
// Computes F = A ? B : C three ways (dataflow, behavioral, gate netlist),
// registers all three with a 1-cycle latency and flags any disagreement.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid, a,b,c : operands, accepted when in_valid is high
//   f_d, f_b, f_s   : registered results of the three forms (held when idle)
//   out_valid       : f_* were updated on the last edge
//   mismatch        : the forms captured on the last edge disagreed
//   mismatch_sticky : a mismatch has been seen since reset
//   eval_count      : accepted evaluations since reset, wrapping
module bool_q1
  import bool_q1_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             f_d,
  output logic             f_b,
  output logic             f_s,
  output logic             out_valid,
  output logic             mismatch,
  output logic             mismatch_sticky,
  output logic [CNT_W-1:0] eval_count
);

  logic f_d_c;
  logic f_b_c;
  logic f_s_c;

  // Dataflow form.
  assign f_d_c = (a & b) | (~a & c);

  // Behavioral form.
  always_comb begin
    f_b_c = 1'b0;
    if (a) begin
      f_b_c = b;
    end else begin
      f_b_c = c;
    end
  end

  // Structural form.
  bool_q1_gates u_gates (
    .a (a),
    .b (b),
    .c (c),
    .f (f_s_c)
  );

  f_forms_t         forms_d,     forms_q;
  logic             out_valid_d, out_valid_q;
  logic             mismatch_d,  mismatch_q;
  logic             sticky_d,    sticky_q;
  logic [CNT_W-1:0] count_d,     count_q;

  always_comb begin
    forms_d     = forms_q;
    out_valid_d = in_valid;
    mismatch_d  = 1'b0;
    count_d     = count_q;
    if (in_valid) begin
      forms_d.f_d = f_d_c;
      forms_d.f_b = f_b_c;
      forms_d.f_s = f_s_c;
      mismatch_d  = forms_disagree(forms_d);
      count_d     = count_q + CNT_W'(1);
    end
    // Sticky sets in the same cycle mismatch is captured.
    sticky_d = sticky_q | mismatch_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      forms_q     <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      forms_q     <= forms_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign f_d             = forms_q.f_d;
  assign f_b             = forms_q.f_b;
  assign f_s             = forms_q.f_s;
  assign out_valid       = out_valid_q;
  assign mismatch        = mismatch_q;
  assign mismatch_sticky = sticky_q;
  assign eval_count      = count_q;

endmodule

// File: tb/tb_bool_q1.sv
// Self-checking bench for bool_q1: a scoreboard queue holds the expected
// result of every accepted input and is drained as out_valid appears.
module tb_bool_q1;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          a;
  logic          b;
  logic          c;
  logic          f_d;
  logic          f_b;
  logic          f_s;
  logic          out_valid;
  logic          mismatch;
  logic          mismatch_sticky;
  logic [CW-1:0] eval_count;

  bool_q1 #(
    .CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .a               (a),
    .b               (b),
    .c               (c),
    .f_d             (f_d),
    .f_b             (f_b),
    .f_s             (f_s),
    .out_valid       (out_valid),
    .mismatch        (mismatch),
    .mismatch_sticky (mismatch_sticky),
    .eval_count      (eval_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic fd;   // expected f_d and f_b
    logic fs;   // expected f_s
    logic mis;  // expected mismatch
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    tt;
  int            n_chk;
  int            n_bad;

  // Bench-side model state.
  logic          m_fd;
  logic          m_fs;
  logic          m_ov;
  logic          m_sticky;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the model, then check after the edge.
  // fault forces the gate-form output low for this cycle.
  task automatic step(input logic r, input logic v, input logic [2:0] abc, input logic fault);
    exp_t e;
    exp_t got_e;
    logic f_exp;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    {a, b, c} = abc;
    if (fault) force dut.f_s_c = 1'b0;
    f_exp = tt[abc];
    if (r) begin
      sb.delete();
      m_fd     = 1'b0;
      m_fs     = 1'b0;
      m_ov     = 1'b0;
      m_sticky = 1'b0;
      m_cnt    = '0;
    end else begin
      m_ov = v;
      if (v) begin
        e.fd  = f_exp;
        e.fs  = fault ? 1'b0 : f_exp;
        e.mis = (e.fd != e.fs);
        sb.push_back(e);
        m_fd     = e.fd;
        m_fs     = e.fs;
        m_cnt    = m_cnt + CW'(1);
        m_sticky = m_sticky | e.mis;
      end
    end
    @(posedge clk);
    #1;
    if (fault) release dut.f_s_c;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("eval_count", 32'(eval_count), 32'(m_cnt));
    chk("sticky", 32'(mismatch_sticky), 32'(m_sticky));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        got_e = sb.pop_front();
        chk("f_d", 32'(f_d), 32'(got_e.fd));
        chk("f_b", 32'(f_b), 32'(got_e.fd));
        chk("f_s", 32'(f_s), 32'(got_e.fs));
        chk("mismatch", 32'(mismatch), 32'(got_e.mis));
      end
    end else begin
      chk("f_d_hold", 32'(f_d), 32'(m_fd));
      chk("f_b_hold", 32'(f_b), 32'(m_fd));
      chk("f_s_hold", 32'(f_s), 32'(m_fs));
      chk("mismatch_idle", 32'(mismatch), 32'd0);
    end
  endtask

  initial begin
    tt       = 8'hCA;
    n_chk    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    c        = 1'b0;
    m_fd     = 1'b0;
    m_fs     = 1'b0;
    m_ov     = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = '0;

    // Reset, including reset overriding a valid input.
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'b001, 1'b0);

    // Exhaustive sweep, one input per cycle.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 1'b0);
    chk("sweep_count", 32'(eval_count), 32'd8);

    // Capture then hold.
    step(1'b0, 1'b1, 3'b110, 1'b0);
    chk("hold_f_one", 32'(f_d), 32'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("hold_f_still_one", 32'(f_s), 32'd1);

    // Reset wins over a simultaneous valid input.
    step(1'b1, 1'b1, 3'b001, 1'b0);
    chk("rst_count", 32'(eval_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // Counter wrap.
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
    chk("wrap_256", 32'(eval_count), 32'd0);
    step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
    chk("wrap_257", 32'(eval_count), 32'd1);

    // Fault on the gate form with a=0,c=1 (F=1, forced f_s=0).
    step(1'b0, 1'b1, 3'b001, 1'b1);
    chk("fault_mismatch", 32'(mismatch), 32'd1);
    chk("fault_sticky", 32'(mismatch_sticky), 32'd1);
    step(1'b0, 1'b1, 3'b110, 1'b0);
    chk("post_fault_mismatch", 32'(mismatch), 32'd0);
    chk("post_fault_sticky", 32'(mismatch_sticky), 32'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    chk("sticky_cleared", 32'(mismatch_sticky), 32'd0);

    // First cycle after reset accepts normally.
    step(1'b0, 1'b1, 3'b011, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
